// File: rtl/i2c_cfg_seq_pkg.sv
// i2c_cfg_pkg: shared definitions for the I2C configuration sequencer.
// Holds the FSM state encoding, the table-entry field map and the R/W bit.
package i2c_cfg_pkg;

  // Sequencer FSM states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_A_REQ  = 4'd2,
    ST_A_WAIT = 4'd3,
    ST_R_WAIT = 4'd4,
    ST_D_WAIT = 4'd5,
    ST_STOP   = 4'd6,
    ST_GAP    = 4'd7,
    ST_FINISH = 4'd8
  } state_e;

  // Table entry layout: {last, dev[6:0], reg[7:0], data[7:0]}
  localparam int ENTRY_W  = 24;
  localparam int LAST_BIT = 23;
  localparam int DEV_MSB  = 22;
  localparam int DEV_LSB  = 16;
  localparam int REG_MSB  = 15;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // R/W bit appended to the 7-bit device address (0 = write)
  localparam logic RW_WRITE = 1'b0;

  // Address byte for a write transaction to the entry's device
  function automatic logic [7:0] addr_byte(input logic [ENTRY_W-1:0] e);
    return {e[DEV_MSB:DEV_LSB], RW_WRITE};
  endfunction

  // Register-pointer byte of an entry
  function automatic logic [7:0] reg_byte(input logic [ENTRY_W-1:0] e);
    return e[REG_MSB:REG_LSB];
  endfunction

  // Data byte of an entry
  function automatic logic [7:0] data_byte(input logic [ENTRY_W-1:0] e);
    return e[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/i2c_cfg_seq_if.sv
// i2c_cfg_seq_if: command/status bus between the configuration sequencer
// and the I2C byte master. The sequencer drives commands through the
// master modport; the byte master answers through the slave modport.
interface i2c_cfg_seq_if;

  logic       m_start;
  logic       m_stop;
  logic       m_write;
  logic       m_read;
  logic       m_ack_in;
  logic [7:0] m_data_in;
  logic       m_done;
  logic       m_busy;
  logic       m_ack_err;

  modport master (
    output m_start, m_stop, m_write, m_read, m_ack_in, m_data_in,
    input  m_done, m_busy, m_ack_err
  );

  modport slave (
    input  m_start, m_stop, m_write, m_read, m_ack_in, m_data_in,
    output m_done, m_busy, m_ack_err
  );

endinterface

// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: walks a register table and writes each entry to an I2C
// device as START, {dev,W}, reg, data, STOP through an external byte master.
// NACKed entries are retried up to MAX_RETRY times; an entry that keeps
// failing ends the run with err set and its index in err_idx.
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               go,
  output logic [IDX_W-1:0]   tbl_addr,
  input  logic [ENTRY_W-1:0] tbl_entry,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IDX_W-1:0]   err_idx,
  i2c_cfg_seq_if.master      m
);

  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1) + 1;
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1) + 1;
  localparam logic [RTY_W-1:0] RTY_LIM = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_TICKS);

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [RTY_W-1:0]   r_retry;
  logic [GAP_W-1:0]   r_gap;
  logic               r_nack;
  logic [ENTRY_W-1:0] r_entry;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [IDX_W-1:0]   r_err_idx;
  logic               r_start;
  logic               r_stop;
  logic               r_write;
  logic               r_ack_in;
  logic [7:0]         r_data;

  assign tbl_addr    = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_idx     = r_err_idx;
  assign m.m_start   = r_start;
  assign m.m_stop    = r_stop;
  assign m.m_write   = r_write;
  assign m.m_read    = 1'b0;
  assign m.m_ack_in  = r_ack_in;
  assign m.m_data_in = r_data;

  // Sequencer FSM: every output is a register updated on the transition
  // into the state that needs it, so the next byte or STOP request is
  // already on the bus one cycle after m_done, ahead of the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_retry   <= '0;
      r_gap     <= '0;
      r_nack    <= 1'b0;
      r_entry   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_write   <= 1'b0;
      r_ack_in  <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_done   <= 1'b0;
      r_ack_in <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          // a go coinciding with the done pulse belongs to the old run
          if (go && !r_done) begin
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_idx     <= '0;
            r_retry   <= '0;
            r_nack    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_entry <= tbl_entry;
          r_start <= 1'b1;
          r_write <= 1'b1;
          r_data  <= addr_byte(tbl_entry);
          r_state <= ST_A_REQ;
        end
        ST_A_REQ: begin
          // hold START until the master has taken the transaction
          if (m.m_busy) begin
            r_start <= 1'b0;
            r_state <= ST_A_WAIT;
          end
        end
        ST_A_WAIT: begin
          if (m.m_done) begin
            if (m.m_ack_err) begin
              r_nack  <= 1'b1;
              r_stop  <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_data  <= reg_byte(r_entry);
              r_state <= ST_R_WAIT;
            end
          end
        end
        ST_R_WAIT: begin
          if (m.m_done) begin
            if (m.m_ack_err) begin
              r_nack  <= 1'b1;
              r_stop  <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_data  <= data_byte(r_entry);
              r_state <= ST_D_WAIT;
            end
          end
        end
        ST_D_WAIT: begin
          if (m.m_done) begin
            r_nack  <= m.m_ack_err;
            r_stop  <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (m.m_done) begin
            r_stop  <= 1'b0;
            r_write <= 1'b0;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap >= GAP_LIM) begin
            r_nack <= 1'b0;
            if (r_nack && (r_retry < RTY_LIM)) begin
              r_retry <= r_retry + RTY_W'(1);
              r_start <= 1'b1;
              r_write <= 1'b1;
              r_data  <= addr_byte(r_entry);
              r_state <= ST_A_REQ;
            end else if (r_nack) begin
              r_err     <= 1'b1;
              r_err_idx <= r_idx;
              r_state   <= ST_FINISH;
            end else if (r_entry[LAST_BIT]) begin
              r_state <= ST_FINISH;
            end else begin
              // index wraps naturally; a table with no last entry loops
              r_idx   <= r_idx + IDX_W'(1);
              r_retry <= '0;
              r_state <= ST_FETCH;
            end
          end else if (tick) begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_stop  <= 1'b0;
          r_write <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb_i2c_cfg_seq: directed bench for i2c_cfg_seq with a behavioural byte
// master. Expected bus bytes are queued when a run is launched and checked
// as the master model completes each byte or STOP.
module tb_i2c_cfg_seq;

  localparam int IDX_W = 5;
  localparam logic [8:0] SB_STOP = 9'h100;
  localparam logic [8:0] SB_NONE = 9'h1FF;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick = 1'b0;
  logic             go;
  logic [IDX_W-1:0] tbl_addr;
  logic [23:0]      tbl_entry;
  logic             busy;
  logic             done;
  logic             err;
  logic [IDX_W-1:0] err_idx;
  logic [23:0]      tbl [32];

  int n_tests = 0;
  int n_fail  = 0;

  assign tbl_entry = tbl[tbl_addr];

  i2c_cfg_seq_if bus ();

  i2c_cfg_seq #(.IDX_W(IDX_W), .MAX_RETRY(2), .GAP_TICKS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .go        (go),
    .tbl_addr  (tbl_addr),
    .tbl_entry (tbl_entry),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .m         (bus)
  );

  always #5 clk = ~clk;

  // tick strobe: one clk in every four
  int tick_cnt = 0;
  always @(negedge clk) begin
    tick_cnt = (tick_cnt + 1) % 4;
    tick = (tick_cnt == 0);
  end

  // ---------------- behavioural byte master ----------------
  typedef enum int {M_IDLE, M_BYTE, M_DECIDE, M_STOP} mst_e;
  mst_e       mst_state;
  logic [7:0] cur_byte;
  int         bitcnt;
  int         stopcnt;
  int         pos;
  int         mode = 0;
  int         run_id = 0;
  int         nacked_run;
  logic       want_nack;
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  logic [15:0] samp_q[$];

  assign want_nack = (mode == 1 && pos == 1 && nacked_run != run_id) ||
                     (mode == 2 && pos == 0 && cur_byte == 8'h24);

  // byte master: 8 ticks per byte, auto-continues unless m_stop is set
  always @(posedge clk) begin
    if (reset) begin
      mst_state     <= M_IDLE;
      bus.m_busy    <= 1'b0;
      bus.m_done    <= 1'b0;
      bus.m_ack_err <= 1'b0;
      pos           <= 0;
      bitcnt        <= 0;
      stopcnt       <= 0;
      nacked_run    <= -1;
    end else begin
      bus.m_done    <= 1'b0;
      bus.m_ack_err <= 1'b0;
      case (mst_state)
        M_IDLE: if (tick && bus.m_start) begin
          bus.m_busy <= 1'b1;
          cur_byte   <= bus.m_data_in;
          pos        <= 0;
          bitcnt     <= 0;
          mst_state  <= M_BYTE;
        end
        M_BYTE: if (tick) begin
          samp_q.push_back({cur_byte, bus.m_data_in});
          if (bitcnt == 7) begin
            bus.m_done    <= 1'b1;
            bus.m_ack_err <= want_nack;
            if (want_nack && mode == 1) nacked_run <= run_id;
            obs_q.push_back({1'b0, cur_byte});
            pos       <= pos + 1;
            mst_state <= M_DECIDE;
          end else begin
            bitcnt <= bitcnt + 1;
          end
        end
        M_DECIDE: if (tick) begin
          if (bus.m_stop) begin
            stopcnt   <= 0;
            mst_state <= M_STOP;
          end else if (bus.m_write) begin
            cur_byte  <= bus.m_data_in;
            bitcnt    <= 0;
            mst_state <= M_BYTE;
          end else begin
            bus.m_busy <= 1'b0;
            mst_state  <= M_IDLE;
          end
        end
        M_STOP: if (tick) begin
          if (stopcnt == 1) begin
            bus.m_done <= 1'b1;
            bus.m_busy <= 1'b0;
            obs_q.push_back(SB_STOP);
            mst_state  <= M_IDLE;
          end else begin
            stopcnt <= stopcnt + 1;
          end
        end
        default: mst_state <= M_IDLE;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock, sampled on the falling edge, then score pending output
  task automatic step();
    logic [8:0]  o;
    logic [8:0]  e;
    logic [15:0] s;
    @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : SB_NONE;
      check("bus_byte", {23'd0, o}, {23'd0, e});
    end
    while (samp_q.size() > 0) begin
      s = samp_q.pop_front();
      check("data_stable", {24'd0, s[7:0]}, {24'd0, s[15:8]});
    end
    if (bus.m_start === 1'b1 || bus.m_stop === 1'b1)
      check("start_with_stop", {31'd0, bus.m_start & bus.m_stop}, 32'd0);
  endtask

  logic [31:0] addr_seen;

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (busy === 1'b1) addr_seen[tbl_addr] = 1'b1;
      if (done === 1'b1) got = 1'b1;
    end
    check("done_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic push_txn(input logic [23:0] e);
    exp_q.push_back({1'b0, e[22:16], 1'b0});
    exp_q.push_back({1'b0, e[15:8]});
    exp_q.push_back({1'b0, e[7:0]});
    exp_q.push_back(SB_STOP);
  endtask

  task automatic load_two();
    tbl[0] = 24'h3C10A5;
    tbl[1] = 24'hBC115A;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit hit;
    reset = 1'b1;
    go    = 1'b0;
    addr_seen = 32'd0;
    for (int i = 0; i < 32; i++) tbl[i] = 24'h000000;
    repeat (3) step();

    // reset state
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_err",    {31'd0, err},  32'd0);
    check("rst_addr",   {27'd0, tbl_addr}, 32'd0);
    check("rst_start",  {31'd0, bus.m_start}, 32'd0);
    check("rst_stop",   {31'd0, bus.m_stop},  32'd0);
    check("rst_write",  {31'd0, bus.m_write}, 32'd0);
    check("rst_ack_in", {31'd0, bus.m_ack_in}, 32'd0);
    check("rst_data",   {24'd0, bus.m_data_in}, 32'd0);
    reset = 1'b0;
    step();
    check("ack_in_high", {31'd0, bus.m_ack_in}, 32'd1);
    check("read_low",    {31'd0, bus.m_read},   32'd0);

    // two entries, slave always ACKs
    load_two();
    mode = 0;
    run_id++;
    push_txn(tbl[0]);
    push_txn(tbl[1]);
    pulse_go();
    check("busy_after_go", {31'd0, busy}, 32'd1);
    wait_done(3000);
    check("t1_err",  {31'd0, err},  32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_sb_left", exp_q.size(), 32'd0);
    repeat (4) step();

    // reg byte of entry 0 NACKed once, then retried
    mode = 1;
    run_id++;
    exp_q.push_back(9'h078);
    exp_q.push_back(9'h010);
    exp_q.push_back(SB_STOP);
    push_txn(tbl[0]);
    push_txn(tbl[1]);
    pulse_go();
    wait_done(4000);
    check("t2_err", {31'd0, err}, 32'd0);
    check("t2_sb_left", exp_q.size(), 32'd0);
    repeat (4) step();

    // address of entry 2 always NACKed: three attempts then error
    mode = 2;
    run_id++;
    for (int i = 0; i < 4; i++) tbl[i] = {1'b0, 7'(8'h10 + i), 8'(8'h20 + i), 8'(8'h40 + i)};
    tbl[3][23] = 1'b1;
    push_txn(tbl[0]);
    push_txn(tbl[1]);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(9'h024);
      exp_q.push_back(SB_STOP);
    end
    addr_seen = 32'd0;
    pulse_go();
    wait_done(6000);
    check("t3_err",     {31'd0, err}, 32'd1);
    check("t3_err_idx", {27'd0, err_idx}, 32'd2);
    check("t3_seen2",   {31'd0, addr_seen[2]}, 32'd1);
    check("t3_no_idx3", {31'd0, addr_seen[3]}, 32'd0);
    check("t3_sb_left", exp_q.size(), 32'd0);
    repeat (4) step();

    // go while busy is ignored; go together with done is ignored
    mode = 0;
    run_id++;
    load_two();
    push_txn(tbl[0]);
    push_txn(tbl[1]);
    pulse_go();
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    repeat (50) step();
    pulse_go();
    repeat (100) step();
    pulse_go();
    wait_done(3000);
    go = 1'b1;
    step();
    go = 1'b0;
    check("t4_go_with_done", {31'd0, busy}, 32'd0);
    step();
    check("t4_still_idle", {31'd0, busy}, 32'd0);
    check("t4_sb_left", exp_q.size(), 32'd0);

    // reset during the data byte abandons the run
    push_txn(tbl[0]);
    push_txn(tbl[1]);
    pulse_go();
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step();
      if (mst_state == M_BYTE && pos == 2) hit = 1'b1;
    end
    check("t5_reach_data", {31'd0, hit}, 32'd1);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("t5_busy",  {31'd0, busy}, 32'd0);
    check("t5_start", {31'd0, bus.m_start}, 32'd0);
    check("t5_stop",  {31'd0, bus.m_stop},  32'd0);
    check("t5_write", {31'd0, bus.m_write}, 32'd0);
    check("t5_data",  {24'd0, bus.m_data_in}, 32'd0);
    check("t5_done",  {31'd0, done}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    samp_q.delete();
    step();
    push_txn(tbl[0]);
    push_txn(tbl[1]);
    pulse_go();
    check("t5_restart_idx", {27'd0, tbl_addr}, 32'd0);
    wait_done(3000);
    check("t5_err", {31'd0, err}, 32'd0);
    check("t5_sb_left", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
- REQ-001 Parameter IDX_W, default 5, sets the table index width (32 entries max).
- REQ-002 Parameter MAX_RETRY, default 2, sets the retries per entry after a NACK.
- REQ-003 Parameter GAP_TICKS, default 4, sets the idle ticks after each STOP.
- REQ-004 One clock; reset is synchronous and active-high.
- REQ-005 clk  in  1  system clock.
- REQ-006 reset  in  1  synchronous active-high reset.
- REQ-007 tick  in  1  bit-phase strobe shared with the master; never asserted on two consecutive clk cycles.
- REQ-008 go  in  1  one-cycle pulse that starts a table run; ignored while busy=1.
- REQ-009 tbl_addr  out  IDX_W  table index being fetched.
- REQ-010 tbl_entry  in  24  {last[23], dev[22:16], reg[15:8], data[7:0]}, valid combinationally from tbl_addr.
- REQ-011 busy  out  1  run in progress.
- REQ-012 done  out  1  one-cycle pulse at the end of a run.
- REQ-013 err  out  1  error flag for the last run, held until the next go.
- REQ-014 err_idx  out  IDX_W  index of the failing entry, valid when err=1.
- REQ-015 m_start, m_stop, m_write, m_read, m_ack_in  out  1 each  command levels to the byte master.
- REQ-016 m_data_in  out  8  byte sent to the master.
- REQ-017 m_done, m_busy, m_ack_err  in  1 each  master status.

Function
- REQ-018 Each entry SHALL be written as one transaction: START, {dev,0}, reg, data, STOP.
- REQ-019 The FSM states SHALL be IDLE, FETCH, A_REQ, A_WAIT, R_WAIT, D_WAIT, STOP, GAP, FINISH.
- REQ-020 IDLE: on go, the FSM SHALL clear err, set idx=0, set retry=0, set busy=1, and go to FETCH.
- REQ-021 FETCH: the FSM SHALL latch tbl_entry into an entry register, then go to A_REQ.
- REQ-022 A_REQ: the FSM SHALL drive m_start=1, m_write=1, m_data_in={dev,1'b0}, and go to A_WAIT once m_busy=1.
- REQ-023 m_start SHALL be 1 only in A_REQ.
- REQ-024 A_WAIT: on m_done, the FSM SHALL go to STOP with nack=1 if m_ack_err=1; otherwise it SHALL go to R_WAIT with m_data_in=reg.
- REQ-025 R_WAIT: on m_done, the FSM SHALL handle NACK the same way; otherwise it SHALL go to D_WAIT with m_data_in=data.
- REQ-026 D_WAIT: on m_done, the FSM SHALL go to STOP and record nack=m_ack_err.
- REQ-027 m_data_in and m_stop SHALL update in the clk cycle after m_done, before the next tick, so the master never auto-continues with a stale byte.
- REQ-028 STOP: m_stop SHALL be 1 until m_done.
- REQ-029 On leaving STOP, the FSM SHALL clear the gap counter and go to GAP.
- REQ-030 GAP: the FSM SHALL count GAP_TICKS ticks, then branch in priority order:
  - nack=1 and retry<MAX_RETRY: retry++, go to A_REQ (same entry);
  - nack=1 and retry=MAX_RETRY: err=1, err_idx=idx, go to FINISH;
  - last=1: go to FINISH;
  - otherwise: idx++, retry=0, go to FETCH.
- REQ-031 FINISH: the FSM SHALL pulse done for 1 cycle, clear busy, and go to IDLE.
- REQ-032 idx SHALL wrap modulo 2^IDX_W; a table without a last entry SHALL loop without bound, and this is a legal configuration.
- REQ-033 m_write SHALL be 1 from A_REQ through STOP and 0 otherwise; m_read SHALL always be 0; m_ack_in SHALL always be 1.
- REQ-034 go arriving together with done SHALL be ignored; a new run requires busy=0 when go is sampled.
- REQ-035 m_done seen in IDLE, FETCH, GAP or FINISH SHALL be ignored.

Reset
- REQ-036 On reset the FSM SHALL be in IDLE with all outputs 0; idx, retry, the gap counter, nack and the entry register SHALL all be 0.
- REQ-037 Reset mid-transaction SHALL abandon the run immediately; no STOP is issued, and the master is reset by the same reset.

Structure
- REQ-038 Package i2c_cfg_pkg SHALL hold the FSM state encoding, the tbl_entry field positions (LAST_BIT, DEV_MSB/LSB, REG_MSB/LSB, DATA_MSB/LSB) and the R/W bit constant.
- REQ-039 The block SHALL be a single module with no sub-module; i2c_master SHALL be instantiated alongside it at the parent level.

Verification
- REQ-040 Two entries {0,0x3C,0x10,0xA5},{1,0x3C,0x11,0x5A}, slave always ACKs -> bytes 0x78,0x10,0xA5,STOP, then 0x78,0x11,0x5A,STOP; done=1, err=0.
- REQ-041 Slave NACKs the reg byte of entry 0 once -> STOP, GAP, entry 0 retried, then the run completes with err=0.
- REQ-042 Slave always NACKs the address of entry 2 (MAX_RETRY=2) -> 3 attempts, err=1, err_idx=2, done pulses, entry 3 is never fetched.
- REQ-043 go pulsed while busy=1 -> ignored; tbl_addr sequence unchanged.
- REQ-044 Reset asserted during D_WAIT -> next cycle busy=0, all m_* outputs 0; a fresh go restarts at idx 0.
- REQ-045 Check every run: m_data_in is stable at each tick where the master samples it, and m_stop is never 1 with m_start.
